// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence scan controller.
// Holds the FSM state encodings, the default widths and the default pattern.
package seq_pkg;

    // FSM state encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Default widths
    localparam int unsigned PAT_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned TO_W_DEF  = 16;

    // Default pattern; the MSB is the oldest bit received
    localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage : seq_pkg

// File: rtl/pattern_match.sv
// Programmable serial pattern matcher.
// Shifts qualified bits into a history register, tracks how many valid bits
// the history holds (fill) and flags a hit when a full history equals the
// pattern. In non-overlap mode the fill restarts after a hit, so no bit of a
// previous match can take part in the next one.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - synchronous clear of history and fill (new job)
//   shift_en  - shift bit_in in this cycle
//   bit_in    - serial data bit
//   pattern   - pattern to match, MSB oldest
//   overlap   - 1 = overlapping detection
//   hit       - combinational, next-state history matches the pattern
module pattern_match
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_n;

    // Next-state history, saturating fill and comparator
    always_comb begin
        hist_n = {hist[PAT_W-2:0], bit_in};
        fill_n = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
        hit    = shift_en && (fill_n == FILL_W'(PAT_W)) && (hist_n == pattern);
    end

    // History kept on a non-overlap hit; fill masks the stale bits
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_n;
            fill <= (hit && !overlap) ? '0 : fill_n;
        end
    end

endmodule : pattern_match

// File: rtl/seq_scan_ctrl.sv
// Run controller for the serial sequence detection path.
// Accepts a scan job over a valid/ready handshake, gates the qualified bit
// stream into the pattern matcher, counts matches and ends the job on target,
// timeout or abort. All outputs are registered.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cfg_valid/ready   - job handshake (ready in IDLE or DONE)
//   cfg_pattern       - pattern, MSB oldest bit
//   cfg_overlap       - 1 = overlapping detection
//   cfg_target        - matches to finish, 0 = free-run
//   cfg_timeout       - SCAN-cycle limit, 0 = none
//   abort             - cancel job
//   data_in/valid     - serial bit and qualifier
//   match_pulse       - one-cycle pulse per match
//   match_count       - matches in current or last job
//   busy              - in SCAN
//   done, timed_out   - job finished / finished by timeout
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned TO_W  = TO_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             abort,
    input  logic             data_in,
    input  logic             data_valid,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             timed_out
);

    logic [1:0]       state;
    logic [1:0]       state_n;

    // Latched job configuration
    logic [PAT_W-1:0] pattern_q;
    logic             overlap_q;
    logic [CNT_W-1:0] target_q;
    logic [TO_W-1:0]  timeout_q;

    logic [TO_W-1:0]  timer;
    logic [TO_W-1:0]  timer_n;
    logic [CNT_W-1:0] count_n;
    logic             pulse_n;
    logic             done_n;
    logic             timed_out_n;
    logic             load;
    logic             shift_en;
    logic             hit;
    logic             completed;

    assign shift_en = (state == ST_SCAN) && data_valid;

    pattern_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk      (clk),
        .rst      (rst),
        .clr      (load),
        .shift_en (shift_en),
        .bit_in   (data_in),
        .pattern  (pattern_q),
        .overlap  (overlap_q),
        .hit      (hit)
    );

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        count_n     = match_count;
        pulse_n     = 1'b0;
        done_n      = done;
        timed_out_n = timed_out;
        load        = 1'b0;
        completed   = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                // abort outranks a job request in the same cycle
                if (abort) begin
                    state_n     = ST_IDLE;
                    done_n      = 1'b0;
                    timed_out_n = 1'b0;
                end else if (cfg_valid) begin
                    load        = 1'b1;
                    state_n     = ST_SCAN;
                    timer_n     = '0;
                    count_n     = '0;
                    done_n      = 1'b0;
                    timed_out_n = 1'b0;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    // count held; a hit in this cycle is dropped
                    state_n = ST_IDLE;
                    done_n  = 1'b0;
                end else begin
                    timer_n = timer + TO_W'(1);
                    if (hit) begin
                        pulse_n = 1'b1;
                        count_n = match_count + CNT_W'(1);
                        if ((target_q != '0) && (count_n == target_q)) begin
                            completed   = 1'b1;
                            state_n     = ST_DONE;
                            done_n      = 1'b1;
                            timed_out_n = 1'b0;
                        end
                    end
                    // completion wins over a coincident timeout
                    if (!completed && (timeout_q != '0) &&
                        (timer == timeout_q - TO_W'(1))) begin
                        state_n     = ST_DONE;
                        done_n      = 1'b1;
                        timed_out_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, configuration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pattern_q   <= '0;
            overlap_q   <= 1'b0;
            target_q    <= '0;
            timeout_q   <= '0;
            timer       <= '0;
            match_count <= '0;
            match_pulse <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            busy        <= 1'b0;
            cfg_ready   <= 1'b1;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            match_count <= count_n;
            match_pulse <= pulse_n;
            done        <= done_n;
            timed_out   <= timed_out_n;
            busy        <= (state_n == ST_SCAN);
            cfg_ready   <= (state_n != ST_SCAN);
            if (load) begin
                pattern_q <= cfg_pattern;
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
                timeout_q <= cfg_timeout;
            end
        end
    end

endmodule : seq_scan_ctrl

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic [15:0] cfg_timeout;
    logic       abort;
    logic       data_in;
    logic       data_valid;
    logic       match_pulse;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic       timed_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.PAT_W(4), .CNT_W(8), .TO_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .cfg_timeout (cfg_timeout),
        .abort       (abort),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [3:0] pat, input logic ov,
                             input logic [7:0] tgt, input logic [15:0] to);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_overlap = ov;
        cfg_target  = tgt;
        cfg_timeout = to;
        tick();
        cfg_valid   = 1'b0;
        // scribble the config bus; only the latched copy may matter
        cfg_pattern = 4'b0000;
        cfg_target  = 8'd1;
        cfg_timeout = 16'd1;
        check("start_busy", busy, 1'b1);
    endtask

    // feed a bit string (MSB first) and check match_pulse after each bit
    task automatic feed(input string tag, input int n, input logic [15:0] bits,
                        input logic [15:0] pulses);
        for (int i = n - 1; i >= 0; i--) begin
            data_in    = bits[i];
            data_valid = 1'b1;
            tick();
            check($sformatf("%s_pulse%0d", tag, n - i), match_pulse, pulses[i]);
        end
        data_valid = 1'b0;
        data_in    = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_ready"}, cfg_ready, 1'b1);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  done, 1'b0);
        check({tag, "_to"},    timed_out, 1'b0);
        check({tag, "_pulse"}, match_pulse, 1'b0);
        check({tag, "_count"}, match_count, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
        cfg_target = '0; cfg_timeout = '0; abort = 1'b0; data_in = 1'b0;
        data_valid = 1'b0;

        // reset
        tick(); tick();
        rst = 1'b0;
        check_idle_reset("reset");

        // overlap: 1011011 -> pulses after bits 4 and 7
        start_job(4'b1011, 1'b1, 8'd0, 16'd0);
        feed("ovl", 7, 16'b1011011, 16'b0001001);
        check("ovl_count", match_count, 32'd2);
        abort = 1'b1; tick(); abort = 1'b0;
        check("ovl_abort_busy", busy, 1'b0);

        // non-overlap: same stream -> one pulse after bit 4
        start_job(4'b1011, 1'b0, 8'd0, 16'd0);
        check("nov_count_clr", match_count, 32'd0);
        feed("nov", 7, 16'b1011011, 16'b0001000);
        check("nov_count", match_count, 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;

        // target 2: 10111011 -> done right after bit 8
        start_job(4'b1011, 1'b0, 8'd2, 16'd0);
        feed("tgt", 8, 16'b10111011, 16'b00010001);
        check("tgt_done", done, 1'b1);
        check("tgt_to", timed_out, 1'b0);
        check("tgt_ready", cfg_ready, 1'b1);
        check("tgt_busy", busy, 1'b0);
        check("tgt_count", match_count, 32'd2);
        tick();
        check("tgt_done_held", done, 1'b1);

        // timeout 5 with no data: done on the 5th SCAN cycle
        start_job(4'b1011, 1'b0, 8'd0, 16'd5);
        for (int i = 0; i < 4; i++) tick();
        check("to_not_yet", done, 1'b0);
        tick();
        check("to_done", done, 1'b1);
        check("to_flag", timed_out, 1'b1);
        // abort from DONE clears status
        abort = 1'b1; tick(); abort = 1'b0;
        check("to_abort_done", done, 1'b0);
        check("to_abort_flag", timed_out, 1'b0);

        // tie-break: 2nd match on timer==4 with timeout 5 -> completion wins
        start_job(4'b1111, 1'b1, 8'd2, 16'd5);
        feed("tie", 5, 16'b11111, 16'b00011);
        check("tie_done", done, 1'b1);
        check("tie_to", timed_out, 1'b0);
        check("tie_count", match_count, 32'd2);

        // abort mid-scan after one match
        start_job(4'b1011, 1'b0, 8'd0, 16'd0);
        feed("abt", 5, 16'b10110, 16'b00010);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abt_busy", busy, 1'b0);
        check("abt_done", done, 1'b0);
        check("abt_count", match_count, 32'd1);
        check("abt_ready", cfg_ready, 1'b1);

        // reset mid-job on the edge that would complete a match
        start_job(4'b1011, 1'b0, 8'd0, 16'd0);
        feed("rstj", 3, 16'b101, 16'b000);
        data_in = 1'b1; data_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; data_valid = 1'b0;
        check_idle_reset("rstmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_scan_ctrl
